// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Definitions shared by the TMDS receive path (and the matching encoder):
//   - the four 10-bit control tokens sent during blanking
//   - the symbol-alignment FSM state type
//   - symbol and bit-offset widths, plus the offset stepping helper
// -----------------------------------------------------------------------------
package tmds_pkg;

  localparam int SYM_W    = 10;  // one TMDS character
  localparam int OFFSET_W = 4;   // holds bit offsets 0..9

  localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(SYM_W - 1);

  // Control tokens, indexed by {ctrl_1, ctrl_0}.
  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Next bit offset to try while hunting; wraps from the last offset to 0.
  function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] offset);
    if (offset >= LAST_OFFSET) begin
      return '0;
    end
    return offset + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// -----------------------------------------------------------------------------
// tmds_symbol_decode
// Purely combinational decode of one aligned 10-bit TMDS symbol.
// Ports:
//   sym      in  10  aligned symbol
//   is_ctrl  out  1  symbol is one of the four control tokens
//   ctrl     out  2  {ctrl_1, ctrl_0} carried by the token (0 for data)
//   data     out  8  recovered pixel byte (meaningful only for data symbols)
// -----------------------------------------------------------------------------
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output logic             is_ctrl,
  output logic [1:0]       ctrl,
  output logic [7:0]       data
);

  logic [7:0] p;

  // NOTE: every variable written in an always_comb gets a default at the top,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (sym)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default:       is_ctrl = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR transition coding
  // selected by bit 8.
  always_comb begin
    p       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = p[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (p[i] ^ p[i-1]) : (p[i] ~^ p[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
// One DVI channel receiver: finds the 10-bit symbol boundary in a raw
// deserialized stream, then decodes pixel data, control bits and data-enable.
// Lock is acquired by dwelling on each bit offset looking for a run of control
// tokens, and dropped when no control token has been seen for a long time.
// Parameters:
//   CTRL_RUN       consecutive control tokens needed to lock
//   SEARCH_CYCLES  dwell time per offset before trying the next one
//   LOCK_TIMEOUT   cycles without a control token before lock is dropped
// Ports:
//   i_clk      in   1  TMDS character clock
//   i_rst      in   1  synchronous active-high reset
//   i_tmds     in  10  raw word, bit 0 earliest on the wire, any alignment
//   o_data     out  8  decoded pixel data (0 when not a data symbol)
//   o_ctrl_0   out  1  control bit 0, held from the last control token
//   o_ctrl_1   out  1  control bit 1, held from the last control token
//   o_data_en  out  1  high while the output is a decoded data symbol
//   o_locked   out  1  symbol alignment established
//   o_offset   out  4  current bit offset, 0..9
// Latency: word sampled on edge k (offset 0) -> r_prev at k, r_sym at k+1,
// outputs at k+2.
// -----------------------------------------------------------------------------
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN      = 4,
  parameter int SEARCH_CYCLES = 2048,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SYM_W-1:0]    i_tmds,
  output logic [7:0]          o_data,
  output logic                o_ctrl_0,
  output logic                o_ctrl_1,
  output logic                o_data_en,
  output logic                o_locked,
  output logic [OFFSET_W-1:0] o_offset
);

  localparam int TIMER_MAX = (SEARCH_CYCLES > LOCK_TIMEOUT) ? SEARCH_CYCLES : LOCK_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int RUN_W     = $clog2(CTRL_RUN + 1);

  localparam logic [TIMER_W-1:0] SEARCH_LAST = TIMER_W'(SEARCH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [RUN_W-1:0]   RUN_TARGET  = RUN_W'(CTRL_RUN);

  // Alignment pipeline
  logic [SYM_W-1:0] r_prev;
  logic [SYM_W-1:0] r_sym;
  logic [SYM_W-1:0] aligned;

  // Decoded view of r_sym
  logic             sym_is_ctrl;
  logic [1:0]       sym_ctrl;
  logic [7:0]       sym_data;

  // FSM and counters
  state_t                state, state_next;
  logic [RUN_W-1:0]      run, run_next, run_inc;
  logic [TIMER_W-1:0]    timer, timer_next, timer_inc;
  logic [OFFSET_W-1:0]   offset_next;
  logic                  skip, skip_next;

  // Output register inputs
  logic [7:0]            data_next;
  logic [1:0]            ctrl_next;
  logic                  data_en_next;

  // Pick the 10-bit window starting o_offset bits into {current, previous}.
  always_comb begin
    aligned = SYM_W'({i_tmds, r_prev} >> o_offset);
  end

  tmds_symbol_decode u_symbol_decode (
    .sym     (r_sym),
    .is_ctrl (sym_is_ctrl),
    .ctrl    (sym_ctrl),
    .data    (sym_data)
  );

  // Saturating increments: counters hold at all-ones instead of wrapping.
  always_comb begin
    run_inc   = (run == '1)   ? run   : run + 1'b1;
    timer_inc = (timer == '1) ? timer : timer + 1'b1;
  end

  always_comb begin
    state_next  = state;
    run_next    = run;
    timer_next  = timer;
    offset_next = o_offset;
    skip_next   = 1'b0;

    case (state)
      SEARCH: begin
        // After an offset change r_sym still holds a word cut at the old
        // offset; it must not count toward the token run.
        if (!skip && sym_is_ctrl) begin
          run_next = run_inc;
        end else begin
          run_next = '0;
        end

        // Reaching the run wins over a dwell expiry on the same cycle.
        if (!skip && sym_is_ctrl && (run_inc >= RUN_TARGET)) begin
          state_next = LOCKED;
          run_next   = '0;
          timer_next = '0;
        end else if (timer == SEARCH_LAST) begin
          offset_next = next_offset(o_offset);
          run_next    = '0;
          timer_next  = '0;
          skip_next   = 1'b1;
        end else begin
          timer_next = timer_inc;
        end
      end

      LOCKED: begin
        if (sym_is_ctrl) begin
          timer_next = '0;
        end else if (timer == LOCK_LAST) begin
          state_next = SEARCH;
          run_next   = '0;
          timer_next = '0;
        end else begin
          timer_next = timer_inc;
        end
      end

      default: begin
        state_next = SEARCH;
        run_next   = '0;
        timer_next = '0;
      end
    endcase
  end

  // Outputs follow the current state: the lock edge itself still shows blank
  // outputs, and the edge that drops lock still emits the symbol in r_sym.
  always_comb begin
    data_next    = '0;
    data_en_next = 1'b0;
    ctrl_next    = {o_ctrl_1, o_ctrl_0};
    if (state == LOCKED) begin
      if (sym_is_ctrl) begin
        ctrl_next = sym_ctrl;
      end else begin
        data_next    = sym_data;
        data_en_next = 1'b1;
      end
    end else begin
      ctrl_next = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev    <= '0;
      r_sym     <= '0;
      state     <= SEARCH;
      run       <= '0;
      timer     <= '0;
      skip      <= 1'b0;
      o_offset  <= '0;
      o_locked  <= 1'b0;
      o_data    <= '0;
      o_data_en <= 1'b0;
      o_ctrl_0  <= 1'b0;
      o_ctrl_1  <= 1'b0;
    end else begin
      r_prev    <= i_tmds;
      r_sym     <= aligned;
      state     <= state_next;
      run       <= run_next;
      timer     <= timer_next;
      skip      <= skip_next;
      o_offset  <= offset_next;
      o_locked  <= (state_next == LOCKED);
      o_data    <= data_next;
      o_data_en <= data_en_next;
      o_ctrl_0  <= ctrl_next[0];
      o_ctrl_1  <= ctrl_next[1];
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
// Directed bench for tmds_decoder (CTRL_RUN=4, SEARCH_CYCLES=16,
// LOCK_TIMEOUT=32). Symbol sequences are queued with hand-derived expected
// outputs and played either aligned (offset 0, outputs two edges after the
// sampling edge) or shifted by three bits (offset 3, one edge later than the
// aligned capture). Expected output vector layout:
//   {data_en, data[7:0], ctrl_1, ctrl_0, locked, offset[3:0]}
// -----------------------------------------------------------------------------
module tb_tmds_decoder;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] D00 = 10'b0100000000;  // encodes 0x00
  localparam logic [9:0] DFF = 10'b1000000000;  // encodes 0xFF

  logic       i_clk;
  logic       i_rst;
  logic [9:0] i_tmds;
  logic [7:0] o_data;
  logic       o_ctrl_0;
  logic       o_ctrl_1;
  logic       o_data_en;
  logic       o_locked;
  logic [3:0] o_offset;

  tmds_decoder #(
    .CTRL_RUN      (4),
    .SEARCH_CYCLES (16),
    .LOCK_TIMEOUT  (32)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_tmds    (i_tmds),
    .o_data    (o_data),
    .o_ctrl_0  (o_ctrl_0),
    .o_ctrl_1  (o_ctrl_1),
    .o_data_en (o_data_en),
    .o_locked  (o_locked),
    .o_offset  (o_offset)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int bias  = 0;

  logic [9:0]  seq_sym [400];
  logic [15:0] seq_exp [400];
  int          seq_n;

  function automatic logic [15:0] observed();
    return {o_data_en, o_data, o_ctrl_1, o_ctrl_0, o_locked, o_offset};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_seq();
    seq_n = 0;
  endtask

  task automatic add(input logic [9:0] s, input logic en, input logic [7:0] d,
                     input logic [1:0] c, input logic lk, input logic [3:0] off);
    seq_sym[seq_n] = s;
    seq_exp[seq_n] = {en, d, c, lk, off};
    seq_n++;
  endtask

  // Plays the queued symbols at bit offset 0 or 3 and checks each symbol's
  // output slot. At offset 3 each wire word carries the top 3 bits of the
  // current symbol in its low bits and the low 7 bits of the next symbol.
  task automatic run_seq(input string name, input int off);
    int lat;
    logic [9:0] cur;
    logic [9:0] nxt;
    lat = (off == 0) ? 2 : 1;
    for (int m = 0; m < seq_n + lat; m++) begin
      cur = seq_sym[(m < seq_n) ? m : seq_n - 1];
      nxt = seq_sym[(m + 1 < seq_n) ? m + 1 : seq_n - 1];
      i_tmds = (off == 0) ? cur : {nxt[6:0], cur[9:7]};
      tick();
      if (m >= lat) begin
        check($sformatf("%s[%0d]", name, m - lat), observed(), seq_exp[m - lat]);
      end
    end
  endtask

  // Reference DVI encoder with running disparity carried in 'bias'.
  task automatic encode_byte(input logic [7:0] d, output logic [9:0] q);
    int n1d, n1q, n0q;
    logic [8:0] qm;
    n1d = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (bias == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      bias = qm[8] ? bias + n1q - n0q : bias + n0q - n1q;
    end else if ((bias > 0 && n1q > n0q) || (bias < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      bias = bias + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      bias = bias - 2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  initial begin : stim
    logic [9:0] w_rot;
    logic [9:0] q;
    w_rot = {C01[6:0], C01[9:7]};  // C01 shifted so it aligns at offset 3

    // ---- Reset values ----
    i_rst  = 1'b1;
    i_tmds = C00;
    tick();
    check("reset_outputs", observed(), 16'h0000);
    i_rst = 1'b0;

    // ---- 1: aligned blanking then data ----
    clear_seq();
    add(C00, 0, 8'h00, 2'b00, 0, 4'd0);
    add(C00, 0, 8'h00, 2'b00, 0, 4'd0);
    add(C00, 0, 8'h00, 2'b00, 0, 4'd0);
    add(C00, 0, 8'h00, 2'b00, 1, 4'd0);  // 4th token: lock edge, outputs blank
    add(D00, 1, 8'h00, 2'b00, 1, 4'd0);
    add(DFF, 1, 8'hFF, 2'b00, 1, 4'd0);
    add(C00, 0, 8'h00, 2'b00, 1, 4'd0);
    run_seq("lock_aligned", 0);

    // ---- 2: token mapping, ctrl held across data ----
    clear_seq();
    add(D00, 1, 8'h00, 2'b00, 1, 4'd0);
    add(C00, 0, 8'h00, 2'b00, 1, 4'd0);
    add(C01, 0, 8'h00, 2'b01, 1, 4'd0);
    add(C10, 0, 8'h00, 2'b10, 1, 4'd0);
    add(C11, 0, 8'h00, 2'b11, 1, 4'd0);
    add(DFF, 1, 8'hFF, 2'b11, 1, 4'd0);
    add(C00, 0, 8'h00, 2'b00, 1, 4'd0);
    run_seq("tokens", 0);

    // ---- 4: round trip of every byte, blanking token every 16 bytes ----
    clear_seq();
    bias = 0;
    for (int b = 0; b < 256; b++) begin
      if (b % 16 == 0) add(C00, 0, 8'h00, 2'b00, 1, 4'd0);
      encode_byte(8'(b), q);
      add(q, 1, 8'(b), 2'b00, 1, 4'd0);
    end
    add(C00, 0, 8'h00, 2'b00, 1, 4'd0);
    run_seq("round_trip", 0);

    // ---- 3: misaligned stream, offset hunt ----
    i_rst  = 1'b1;
    i_tmds = w_rot;
    tick();
    i_rst = 1'b0;
    for (int e = 1; e <= 53; e++) begin
      tick();
      if (e == 15) check("hunt_off_e15", {12'h0, o_offset}, 16'd0);
      if (e == 16) check("hunt_off_e16", {12'h0, o_offset}, 16'd1);
      if (e == 31) check("hunt_off_e31", {12'h0, o_offset}, 16'd1);
      if (e == 32) check("hunt_off_e32", {12'h0, o_offset}, 16'd2);
      if (e == 47) check("hunt_off_e47", {12'h0, o_offset}, 16'd2);
      if (e == 48) check("hunt_off_e48", {12'h0, o_offset}, 16'd3);
      if (e == 52) check("hunt_unlocked_e52", {15'h0, o_locked}, 16'd0);
      if (e == 53) check("hunt_locked_e53", {11'h0, o_locked, o_offset}, {11'h0, 1'b1, 4'd3});
    end
    clear_seq();
    add(C01, 0, 8'h00, 2'b01, 1, 4'd3);
    add(C01, 0, 8'h00, 2'b01, 1, 4'd3);
    add(D00, 1, 8'h00, 2'b01, 1, 4'd3);
    add(C01, 0, 8'h00, 2'b01, 1, 4'd3);
    run_seq("misaligned_data", 3);

    // ---- 5: lock loss after 32 data symbols, offset retained, relock ----
    clear_seq();
    add(C01, 0, 8'h00, 2'b01, 1, 4'd3);
    for (int k = 1; k <= 32; k++) begin
      if (k % 2 == 1) add(D00, 1, 8'h00, 2'b01, (k < 32), 4'd3);
      else            add(DFF, 1, 8'hFF, 2'b01, (k < 32), 4'd3);
    end
    add(C01, 0, 8'h00, 2'b00, 0, 4'd3);  // back in SEARCH: blank, ctrl forced 00
    add(C01, 0, 8'h00, 2'b00, 0, 4'd3);
    add(C01, 0, 8'h00, 2'b00, 0, 4'd3);
    add(C01, 0, 8'h00, 2'b00, 1, 4'd3);  // relock on the 4th token
    add(C01, 0, 8'h00, 2'b01, 1, 4'd3);
    run_seq("lock_loss", 3);

    // ---- 6: reset mid-lock while data is in flight ----
    clear_seq();
    add(C01, 0, 8'h00, 2'b01, 1, 4'd3);
    add(DFF, 1, 8'hFF, 2'b01, 1, 4'd3);
    add(DFF, 1, 8'hFF, 2'b01, 1, 4'd3);
    run_seq("pre_reset", 3);
    i_rst = 1'b1;
    tick();
    check("reset_mid_lock", observed(), 16'h0000);
    i_rst = 1'b0;
    tick();
    check("after_reset_release", observed(), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
